// File: rtl/sram_mem_controller.sv
// ----------------------------------------------------------------------------
// sram_mem_controller
//
// Memory-stage responder sitting behind the EX/MEM pipeline register. Each
// load or store becomes a 32-bit word access on an external 16-bit
// asynchronous SRAM. The access is split into two half-word phases: LOW moves
// bits 15:0 and HIGH moves bits 31:16. Each phase holds the SRAM bus for
// WAIT_CYCLES clocks. While an access is in flight, ready stalls the pipeline.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   rd_en, wr_en    registered load / store requests (store wins if both high)
//   address         byte address; BASE_ADDR maps to SRAM word 0
//   write_data      store value
//   read_data       word returned by the most recent completed load
//   ready           pipeline advance enable (low = hold EX/MEM)
//   sram_addr       half-word address on the SRAM
//   sram_dq_out     data driven onto the SRAM bus during stores
//   sram_dq_oe      bus drive enable; the top level builds the tristate
//   sram_dq_in      data read back from the SRAM
//   sram_we_n       active-low SRAM write strobe
// ----------------------------------------------------------------------------
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t             state, state_next;
  logic [3:0]         counter, counter_next;
  logic               op, op_next;
  logic [31:0]        read_data_next;
  logic [SRAM_AW-1:0] sram_addr_next;
  logic [15:0]        sram_dq_out_next;
  logic               sram_dq_oe_next;
  logic               sram_we_n_next;
  logic [SRAM_AW-2:0] word;
  logic               last_wait;

  // SRAM word index of the request. The subtraction wraps modulo 2^32, and
  // the byte offset bits are dropped by the shift.
  assign word      = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
  assign last_wait = (counter == WAIT_LAST);

  // ready is only influenced by the request inputs while idle.
  // Once an access starts, ready stays low until the DONE cycle.
  assign ready = (state == DONE) || ((state == IDLE) && !rd_en && !wr_en);

  // State and all SRAM-facing outputs are registered, so the bus is glitch
  // free. Reset releases the bus at once and discards any half-captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= 4'd0;
      op          <= 1'b0;
      read_data   <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= state_next;
      counter     <= counter_next;
      op          <= op_next;
      read_data   <= read_data_next;
      sram_addr   <= sram_addr_next;
      sram_dq_out <= sram_dq_out_next;
      sram_dq_oe  <= sram_dq_oe_next;
      sram_we_n   <= sram_we_n_next;
    end
  end

  // Next-state logic. Bus signals are loaded on the transition into each
  // phase, so they are already valid during the phase's first cycle.
  // A read captures each half on the last cycle of its phase. By then the
  // SRAM has had the full wait time to settle.
  always_comb begin
    state_next       = state;
    counter_next     = counter;
    op_next          = op;
    read_data_next   = read_data;
    sram_addr_next   = sram_addr;
    sram_dq_out_next = sram_dq_out;
    sram_dq_oe_next  = sram_dq_oe;
    sram_we_n_next   = sram_we_n;

    unique case (state)
      IDLE: begin
        if (wr_en || rd_en) begin
          op_next        = wr_en;
          state_next     = LOW;
          counter_next   = 4'd0;
          sram_addr_next = {word, 1'b0};
          if (wr_en) begin
            sram_dq_out_next = write_data[15:0];
            sram_dq_oe_next  = 1'b1;
            sram_we_n_next   = 1'b0;
          end else begin
            sram_dq_oe_next  = 1'b0;
            sram_we_n_next   = 1'b1;
          end
        end
      end

      LOW: begin
        if (last_wait) begin
          state_next     = HIGH;
          counter_next   = 4'd0;
          sram_addr_next = {word, 1'b1};
          if (op) begin
            sram_dq_out_next = write_data[31:16];
          end else begin
            read_data_next[15:0] = sram_dq_in;
          end
        end else begin
          counter_next = counter + 4'd1;
        end
      end

      HIGH: begin
        if (last_wait) begin
          state_next      = DONE;
          counter_next    = 4'd0;
          sram_dq_oe_next = 1'b0;
          sram_we_n_next  = 1'b1;
          if (!op) begin
            read_data_next[31:16] = sram_dq_in;
          end
        end else begin
          counter_next = counter + 4'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Self-checking bench for sram_mem_controller. A behavioural 16-bit SRAM is
// attached to the bus. A word-level reference memory predicts the load
// results, and the bus activity is predicted cycle by cycle from the access
// timing. The bench runs directed scenarios first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_sram_mem_controller;

  localparam int unsigned WAIT = 2;
  localparam int unsigned AW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n;

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_read_data;

  logic [15:0] sram_mem [0:(1<<AW)-1];

  sram_mem_controller #(
    .WAIT_CYCLES(WAIT),
    .BASE_ADDR  (32'd1024),
    .SRAM_AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM. Reads are combinational. A write lands
  // while the strobe is low.
  assign sram_dq_in = sram_mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
  end

  // The 17-bit SRAM word index selected by a byte address.
  function automatic logic [31:0] refWord(input logic [31:0] a);
    return ((a - 32'd1024) >> 2) & 32'h0001_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Idle for n cycles. Entered and left just after a rising edge.
  task automatic idleCycles(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("idle_ready", ready, 1'b1);
      checkOutput("idle_we_n", sram_we_n, 1'b1);
      checkOutput("idle_oe", sram_dq_oe, 1'b0);
      checkOutput("idle_read_data", read_data, ref_read_data);
      @(posedge clk); #1;
    end
  endtask

  // One complete access, starting in an IDLE cycle (just after a rising edge).
  // The task returns at the start of the IDLE cycle that follows DONE, so the
  // next access can be presented immediately.
  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    logic        is_write;
    logic        hi;
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = d;
    is_write   = wr;
    w          = refWord(a);
    #1;
    checkOutput("req_ready", ready, 1'b0);
    for (int k = 1; k <= 2 * WAIT; k++) begin
      @(posedge clk); #1;
      hi = (k > WAIT);
      checkOutput("busy_ready", ready, 1'b0);
      checkOutput("sram_addr", 32'(sram_addr), (w << 1) | 32'(hi));
      checkOutput("we_n", sram_we_n, !is_write);
      checkOutput("oe", sram_dq_oe, is_write);
      if (is_write)
        checkOutput("dq_out", sram_dq_out, hi ? d[31:16] : d[15:0]);
    end
    if (is_write) ref_mem[w] = d;
    else ref_read_data = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
    @(posedge clk); #1;
    checkOutput("done_ready", ready, 1'b1);
    checkOutput("done_we_n", sram_we_n, 1'b1);
    checkOutput("done_oe", sram_dq_oe, 1'b0);
    checkOutput("read_data", read_data, ref_read_data);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
    ref_read_data = 32'd0;
    rst        = 1'b1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_we_n", sram_we_n, 1'b1);
    checkOutput("rst_oe", sram_dq_oe, 1'b0);
    checkOutput("rst_addr", 32'(sram_addr), 32'd0);
    checkOutput("rst_dq_out", sram_dq_out, 16'd0);
    checkOutput("rst_read_data", read_data, 32'd0);

    // Quiet bus
    idleCycles(10);

    // Directed accesses: a write and its read-back, back-to-back traffic,
    // and both enables high at once.
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h12345678);
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5);
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'h0);

    // Addresses below the base wrap around. Byte offset bits are ignored.
    applyStimulus(1'b1, 1'b0, 32'd0, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 32'd2, 32'h0);
    idleCycles(1);

    // Reset during the HIGH phase of a store
    wr_en      = 1'b1;
    rd_en      = 1'b0;
    address    = 32'd1600;
    write_data = 32'h0BADC0DE;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_we_n_active", sram_we_n, 1'b0);
    rst   = 1'b1;
    wr_en = 1'b0;
    ref_read_data = 32'd0;
    #1;
    checkOutput("mid_rst_we_n", sram_we_n, 1'b1);
    checkOutput("mid_rst_oe", sram_dq_oe, 1'b0);
    checkOutput("mid_rst_read_data", read_data, 32'd0);
    checkOutput("mid_rst_ready", ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'h0);

    // Randomized traffic over a small window of words
    for (int n = 0; n < 40; n++) begin
      int unsigned sel;
      logic [31:0] a;
      logic [31:0] d;
      sel = $urandom_range(0, 3);
      a   = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      d   = $urandom;
      case (sel)
        0:       idleCycles(int'($urandom_range(1, 2)));
        1:       applyStimulus(1'b0, 1'b1, a, d);
        2:       applyStimulus(1'b1, 1'b0, a, d);
        default: applyStimulus(1'b1, 1'b1, a, d);
      endcase
    end
    idleCycles(2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
